// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Single-clock memory responder for a small 16-bit CPU. It serves an
//   instruction-fetch port and a load/store port every cycle from a shared
//   word RAM, plus a small MMIO block at 0xF000-0xFFFF:
//     0xF000 LED register   (read/write, drives o_leds)
//     0xF002 switch register (read-only, synchronized i_switches)
//     0xF004 timer register  (free-running cycle counter, any store clears it)
//   All addresses are byte addresses. Bit 0 is ignored, and RAM aliases
//   modulo WORDS.
// Ports
//   clk, reset           rising-edge clock; asynchronous active-high reset
//   i_pc_addr, i_pc_rd   fetch request; o_pc_rddata is valid one cycle later
//   i_ldst_addr/_rd/_wr  load/store request; i_ldst_wrdata is the store data
//   o_ldst_rddata        load data, valid one cycle after the load
//   i_switches           asynchronous board switches
//   o_leds               LED register value
module cpu_mem_responder #(
  parameter int WORDS       = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_pc_addr,
  input  logic        i_pc_rd,
  output logic [15:0] o_pc_rddata,
  input  logic [15:0] i_ldst_addr,
  input  logic        i_ldst_rd,
  input  logic        i_ldst_wr,
  input  logic [15:0] i_ldst_wrdata,
  output logic [15:0] o_ldst_rddata,
  input  logic [15:0] i_switches,
  output logic [15:0] o_leds
);

  localparam int AW = $clog2(WORDS);

  // MMIO register word addresses (byte address >> 1)
  localparam logic [14:0] LED_WA   = 15'h7800;
  localparam logic [14:0] SW_WA    = 15'h7801;
  localparam logic [14:0] TIMER_WA = 15'h7802;

  logic [15:0] mem [WORDS];

  logic [AW-1:0] pc_idx;
  logic [AW-1:0] ls_idx;
  logic          pc_mmio;
  logic          ls_mmio;
  logic          st_ram;
  logic          st_led;
  logic          st_timer;

  logic [15:0] pc_rddata_q, pc_rddata_d;
  logic [15:0] ls_rddata_q, ls_rddata_d;
  logic [15:0] leds_q, leds_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] mmio_rd;
  logic [SYNC_STAGES-1:0][15:0] sync_q;

  // Bit 0 and any address bits above the RAM index are intentionally unused
  // for RAM indexing; they are still consumed by the MMIO decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_pc_addr, i_ldst_addr};

  assign pc_idx  = i_pc_addr[AW:1];
  assign ls_idx  = i_ldst_addr[AW:1];
  assign pc_mmio = (i_pc_addr[15:12] == 4'hF);
  assign ls_mmio = (i_ldst_addr[15:12] == 4'hF);

  // Stores are gated by reset so nothing commits while reset is held.
  assign st_ram   = i_ldst_wr && !ls_mmio && !reset;
  assign st_led   = i_ldst_wr && (i_ldst_addr[15:1] == LED_WA);
  assign st_timer = i_ldst_wr && (i_ldst_addr[15:1] == TIMER_WA);

  // RAM has no reset so a preloaded program survives reset.
  always_ff @(posedge clk) begin
    if (st_ram) begin
      mem[ls_idx] <= i_ldst_wrdata;
    end
  end

  // Fetch path: a same-cycle store to the fetched word is forwarded
  // (write-first), because the array itself only updates at this edge.
  always_comb begin
    pc_rddata_d = pc_rddata_q;
    if (i_pc_rd) begin
      if (pc_mmio) begin
        pc_rddata_d = 16'h0000;
      end else if (st_ram && (ls_idx == pc_idx)) begin
        pc_rddata_d = i_ldst_wrdata;
      end else begin
        pc_rddata_d = mem[pc_idx];
      end
    end
  end

  // MMIO read mux; the timer value returned is the one held at the load edge.
  always_comb begin
    case (i_ldst_addr[15:1])
      LED_WA:   mmio_rd = leds_q;
      SW_WA:    mmio_rd = sync_q[SYNC_STAGES-1];
      TIMER_WA: mmio_rd = timer_q;
      default:  mmio_rd = 16'h0000;
    endcase
  end

  // Load path: a store in the same cycle wins and the load data holds.
  // A load right after a store needs no forwarding since the write has
  // already landed in the array at the previous edge.
  always_comb begin
    ls_rddata_d = ls_rddata_q;
    if (i_ldst_rd && !i_ldst_wr) begin
      ls_rddata_d = ls_mmio ? mmio_rd : mem[ls_idx];
    end
  end

  always_comb begin
    leds_d = leds_q;
    if (st_led) begin
      leds_d = i_ldst_wrdata;
    end
  end

  assign timer_d = st_timer ? 16'h0000 : timer_q + 16'h0001;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_rddata_q <= 16'h0000;
      ls_rddata_q <= 16'h0000;
      leds_q      <= 16'h0000;
      timer_q     <= 16'h0000;
    end else begin
      pc_rddata_q <= pc_rddata_d;
      ls_rddata_q <= ls_rddata_d;
      leds_q      <= leds_d;
      timer_q     <= timer_d;
    end
  end

  // Switch synchronizer chain; stage 0 samples the asynchronous pins.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q[gi] <= 16'h0000;
        end else if (gi == 0) begin
          sync_q[gi] <= i_switches;
        end else begin
          sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign o_pc_rddata   = pc_rddata_q;
  assign o_ldst_rddata = ls_rddata_q;
  assign o_leds        = leds_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i_pc_addr;
  logic        i_pc_rd;
  logic [15:0] o_pc_rddata;
  logic [15:0] i_ldst_addr;
  logic        i_ldst_rd;
  logic        i_ldst_wr;
  logic [15:0] i_ldst_wrdata;
  logic [15:0] o_ldst_rddata;
  logic [15:0] i_switches;
  logic [15:0] o_leds;

  always #5 clk = ~clk;

  cpu_mem_responder #(.WORDS(4096), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pc_addr     (i_pc_addr),
    .i_pc_rd       (i_pc_rd),
    .o_pc_rddata   (o_pc_rddata),
    .i_ldst_addr   (i_ldst_addr),
    .i_ldst_rd     (i_ldst_rd),
    .i_ldst_wr     (i_ldst_wr),
    .i_ldst_wrdata (i_ldst_wrdata),
    .o_ldst_rddata (o_ldst_rddata),
    .i_switches    (i_switches),
    .o_leds        (o_leds)
  );

  typedef struct {
    bit          is_pc;
    logic [15:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp;
    string       name;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%04h", name, act);
    end
  endtask

  task automatic expect_pc(input logic [15:0] exp, input string name);
    sb_t e;
    e.is_pc = 1'b1; e.exp = exp; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic expect_ld(input logic [15:0] exp, input string name);
    sb_t e;
    e.is_pc = 1'b0; e.exp = exp; e.name = name;
    sb_q.push_back(e);
  endtask

  // Everything queued was driven before the edge just taken, so with
  // one-cycle latency all of it is due now.
  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, e.is_pc ? o_pc_rddata : o_ldst_rddata, e.exp);
    end
  endtask

  task automatic step(input logic pc_rd, input logic [15:0] pc_addr,
                      input logic ld_rd, input logic ld_wr,
                      input logic [15:0] ld_addr, input logic [15:0] wd);
    i_pc_rd       = pc_rd;
    i_pc_addr     = pc_addr;
    i_ldst_rd     = ld_rd;
    i_ldst_wr     = ld_wr;
    i_ldst_addr   = ld_addr;
    i_ldst_wrdata = wd;
    @(posedge clk);
    #1;
    i_pc_rd   = 1'b0;
    i_ldst_rd = 1'b0;
    i_ldst_wr = 1'b0;
    drain();
  endtask

  task automatic idle();
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    reset = 1'b1;
    i_pc_addr = '0; i_pc_rd = 1'b0; i_ldst_addr = '0; i_ldst_rd = 1'b0;
    i_ldst_wr = 1'b0; i_ldst_wrdata = '0; i_switches = 16'h0000;

    // Reset state
    @(posedge clk); #1;
    check("reset_pc",   o_pc_rddata,   16'h0000);
    check("reset_ld",   o_ldst_rddata, 16'h0000);
    check("reset_leds", o_leds,        16'h0000);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // Load/store vector table
    vecs.push_back('{0, 1, 16'h0010, 16'h1234, 16'h0000, "st_0010"});
    vecs.push_back('{1, 0, 16'h0011, 16'h0000, 16'h1234, "ld_after_st_odd"});
    vecs.push_back('{0, 1, 16'h2000, 16'h00AA, 16'h0000, "st_2000"});
    vecs.push_back('{1, 0, 16'h0000, 16'h0000, 16'h00AA, "ld_alias_0000"});
    vecs.push_back('{0, 1, 16'h0FFE, 16'h7777, 16'h0000, "st_0ffe"});
    vecs.push_back('{1, 0, 16'hEFFE, 16'h0000, 16'h7777, "ld_alias_effe"});
    vecs.push_back('{0, 1, 16'h0100, 16'hCAFE, 16'h0000, "st_0100"});
    vecs.push_back('{1, 0, 16'h0010, 16'h0000, 16'h1234, "ld_0010"});
    vecs.push_back('{1, 1, 16'h0100, 16'hD00D, 16'h1234, "rdwr_hold"});
    vecs.push_back('{1, 0, 16'h0100, 16'h0000, 16'hD00D, "ld_after_rdwr"});
    vecs.push_back('{0, 1, 16'hF000, 16'h5A5A, 16'h0000, "st_leds"});
    vecs.push_back('{1, 0, 16'hF000, 16'h0000, 16'h5A5A, "ld_leds"});
    vecs.push_back('{1, 0, 16'hF001, 16'h0000, 16'h5A5A, "ld_leds_odd"});
    vecs.push_back('{0, 1, 16'hF008, 16'h1111, 16'h0000, "st_unmapped"});
    vecs.push_back('{1, 0, 16'hF008, 16'h0000, 16'h0000, "ld_unmapped"});
    vecs.push_back('{1, 0, 16'hF006, 16'h0000, 16'h0000, "ld_unmapped2"});

    foreach (vecs[i]) begin
      if (vecs[i].rd) expect_ld(vecs[i].exp, vecs[i].name);
      step(1'b0, 16'h0000, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
    end
    check("leds_out", o_leds, 16'h5A5A);

    // Fetch port: write-first on same-cycle store, MMIO fetch, hold
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0022, 16'h4444);
    expect_pc(16'hBEEF, "fetch_wr_first");
    step(1'b1, 16'h0020, 1'b0, 1'b1, 16'h0020, 16'hBEEF);
    expect_pc(16'h4444, "fetch_0022");
    step(1'b1, 16'h0022, 1'b0, 1'b0, 16'h0000, 16'h0000);
    expect_pc(16'h1234, "fetch_0010");
    step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    expect_pc(16'h1234, "fetch_hold");
    idle();
    expect_pc(16'h0000, "fetch_mmio");
    step(1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    expect_pc(16'h0000, "fetch_hold_mmio");
    idle();

    // Switch synchronizer and read-only switch register
    i_switches = 16'h0F0F;
    idle(); idle(); idle();
    expect_ld(16'h0F0F, "ld_switches");
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'hF002, 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'hF002, 16'hFFFF);
    i_switches = 16'hA5A5;
    expect_ld(16'h0F0F, "ld_switches_lag");
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'hF002, 16'h0000);
    idle();
    expect_ld(16'hA5A5, "ld_switches_new");
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'hF002, 16'h0000);

    // Timer clear, count and wrap
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'hF004, 16'h9999);
    for (int i = 0; i < 10; i++) idle();
    expect_ld(16'd10, "timer_10");
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'hF004, 16'h0000);
    for (int i = 0; i < 65535; i++) idle();
    expect_ld(16'd10, "timer_wrap");
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'hF004, 16'h0000);

    // Reset between a load and its data
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'h3C3C);
    i_ldst_addr = 16'h0040; i_ldst_rd = 1'b1;
    @(posedge clk);
    i_ldst_rd = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_ld",   o_ldst_rddata, 16'h0000);
    check("rst_mid_leds", o_leds,        16'h0000);
    // Stores presented during reset must be ignored
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'h9999);
    check("rst_store_leds", o_leds, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    idle();
    check("rst_no_ghost", o_ldst_rddata, 16'h0000);
    expect_ld(16'h3C3C, "ram_survives_rst");
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
    expect_pc(16'h1234, "ram_survives_rst_pc");
    step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
